// File: rtl/scr1_ahb_rsp_pkg.sv
// Shared definitions for the SCR1 AHB-Lite SRAM responder: FSM states,
// AHB constants and the byte-lane mask helper.
package scr1_ahb_rsp_pkg;

    // AHB-Lite bus width and transfer-type encodings
    localparam int         SCR1_AHB_WIDTH     = 32;
    localparam logic [1:0] SCR1_HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] SCR1_HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] SCR1_HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] SCR1_HTRANS_SEQ    = 2'b11;

    // HSIZE encodings supported by the responder
    localparam logic [2:0] SCR1_HSIZE_8B  = 3'd0;
    localparam logic [2:0] SCR1_HSIZE_16B = 3'd1;
    localparam logic [2:0] SCR1_HSIZE_32B = 3'd2;

    typedef enum logic [2:0] {
        SCR1_AHB_RSP_FSM_IDLE,
        SCR1_AHB_RSP_FSM_WAIT,
        SCR1_AHB_RSP_FSM_DATA,
        SCR1_AHB_RSP_FSM_ERR1,
        SCR1_AHB_RSP_FSM_ERR2
    } type_scr1_ahb_rsp_fsm_e;

    // Lane mask for a naturally aligned access; unsupported sizes select nothing
    function automatic logic [3:0] ahb_rsp_byte_en(input logic [2:0] hsize,
                                                   input logic [1:0] addr);
        logic [3:0] be;
        case (hsize)
            SCR1_HSIZE_8B:  be = 4'b0001 << addr;
            SCR1_HSIZE_16B: be = addr[1] ? 4'b1100 : 4'b0011;
            SCR1_HSIZE_32B: be = 4'b1111;
            default:        be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/scr1_ahb_rsp_ram.sv
// Word-organised SRAM with per-byte write enables, synchronous write and
// asynchronous read. Contents are never reset.
module scr1_ahb_rsp_ram
    import scr1_ahb_rsp_pkg::*;
#(
    parameter int MEM_POWER_SIZE = 16
) (
    input  logic                        clk,
    input  logic                        we_i,
    input  logic [3:0]                  be_i,
    input  logic [MEM_POWER_SIZE-3:0]   waddr_i,
    input  logic [SCR1_AHB_WIDTH-1:0]   wdata_i,
    input  logic [MEM_POWER_SIZE-3:0]   raddr_i,
    output logic [SCR1_AHB_WIDTH-1:0]   rdata_o
);

    localparam int DEPTH = 2 ** (MEM_POWER_SIZE - 2);

    logic [SCR1_AHB_WIDTH-1:0] mem [DEPTH];

    // Byte-lane write: only enabled lanes of the addressed word change
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < 4; i++) begin
                if (be_i[i]) begin
                    mem[waddr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
                end
            end
        end
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/scr1_ahb_sram_rsp.sv
// AHB-Lite responder terminating one SCR1 AHB port with a byte-addressable
// SRAM. Zero-wait pipelined transfers, two-cycle ERROR responses and, when
// SCR1_AHB_RSP_STALL_EN is defined, per-transfer wait states from stall_in.
module scr1_ahb_sram_rsp
    import scr1_ahb_rsp_pkg::*;
#(
    parameter int MEM_POWER_SIZE = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [1:0]                  htrans,
    input  logic [SCR1_AHB_WIDTH-1:0]   haddr,
    input  logic                        hwrite,
    input  logic [2:0]                  hsize,
    input  logic [SCR1_AHB_WIDTH-1:0]   hwdata,
`ifdef SCR1_AHB_RSP_STALL_EN
    input  logic [3:0]                  stall_in,
`endif
    output logic                        hready,
    output logic [SCR1_AHB_WIDTH-1:0]   hrdata,
    output logic                        hresp
);

    type_scr1_ahb_rsp_fsm_e     state_q, state_d;
    logic [MEM_POWER_SIZE-1:0]  addr_q;
    logic                       write_q;
    logic [2:0]                 size_q;
    logic [3:0]                 wait_q, wait_d;

    logic                       accept;
    logic                       req_err;
    logic [3:0]                 stall_req;
    logic                       mem_we;
    logic [SCR1_AHB_WIDTH-1:0]  mem_rdata;

`ifdef SCR1_AHB_RSP_STALL_EN
    assign stall_req = stall_in;
`else
    assign stall_req = 4'd0;
`endif

    assign accept = hready & htrans[1];

    // Out-of-range address, unsupported size or misalignment
    assign req_err = (|haddr[SCR1_AHB_WIDTH-1:MEM_POWER_SIZE])
                   | (hsize > SCR1_HSIZE_32B)
                   | ((hsize == SCR1_HSIZE_16B) & haddr[0])
                   | ((hsize == SCR1_HSIZE_32B) & (|haddr[1:0]));

    // State register plus address-phase capture on accept
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SCR1_AHB_RSP_FSM_IDLE;
            wait_q  <= 4'd0;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (accept) begin
                addr_q  <= haddr[MEM_POWER_SIZE-1:0];
                write_q <= hwrite;
                size_q  <= hsize;
            end
        end
    end

    // Next state: IDLE, DATA and ERR2 all end a data phase and may start the next
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            SCR1_AHB_RSP_FSM_WAIT: begin
                wait_d = wait_q - 4'd1;
                if (wait_q <= 4'd1) begin
                    wait_d  = 4'd0;
                    state_d = SCR1_AHB_RSP_FSM_DATA;
                end
            end
            SCR1_AHB_RSP_FSM_ERR1: state_d = SCR1_AHB_RSP_FSM_ERR2;
            default: begin
                if (!accept) begin
                    state_d = SCR1_AHB_RSP_FSM_IDLE;
                end else if (req_err) begin
                    state_d = SCR1_AHB_RSP_FSM_ERR1;
                end else if (stall_req != 4'd0) begin
                    state_d = SCR1_AHB_RSP_FSM_WAIT;
                    wait_d  = stall_req;
                end else begin
                    state_d = SCR1_AHB_RSP_FSM_DATA;
                end
            end
        endcase
    end

    // Bus response decoded from state; read data only visible in DATA
    always_comb begin
        hready = 1'b1;
        hresp  = 1'b0;
        hrdata = '0;
        case (state_q)
            SCR1_AHB_RSP_FSM_WAIT: hready = 1'b0;
            SCR1_AHB_RSP_FSM_DATA: hrdata = mem_rdata;
            SCR1_AHB_RSP_FSM_ERR1: begin
                hready = 1'b0;
                hresp  = 1'b1;
            end
            SCR1_AHB_RSP_FSM_ERR2: hresp = 1'b1;
            default: ;
        endcase
    end

    // A reset arriving in the final data-phase cycle abandons the write
    assign mem_we = (state_q == SCR1_AHB_RSP_FSM_DATA) & write_q & ~rst;

    scr1_ahb_rsp_ram #(
        .MEM_POWER_SIZE (MEM_POWER_SIZE)
    ) i_ram (
        .clk     (clk),
        .we_i    (mem_we),
        .be_i    (ahb_rsp_byte_en(size_q, addr_q[1:0])),
        .waddr_i (addr_q[MEM_POWER_SIZE-1:2]),
        .wdata_i (hwdata),
        .raddr_i (addr_q[MEM_POWER_SIZE-1:2]),
        .rdata_o (mem_rdata)
    );

endmodule
